// File: rtl/snr_sweep_scheduler.sv
// Sequences the channel generator through a descending-sigma sweep and forwards
// each captured block to the decoder. Define SCHED_TIMEOUT_EN to enable the REQUEST watchdog.
module snr_sweep_scheduler #(
  parameter int N              = 204,
  parameter int QUAN_SIZE      = 4,
  parameter int FRAME_CNT_W    = 16,
  parameter int SNR_IDX_W      = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      sys_clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [15:0]               sigma_init,
  input  logic [15:0]               sigma_step,
  input  logic [SNR_IDX_W-1:0]      num_points,
  input  logic [FRAME_CNT_W-1:0]    frames_per_point,
  output logic [15:0]               gen_sigma,
  output logic                      gen_ready,
  input  logic                      gen_tvalid,
  input  logic [N*QUAN_SIZE-1:0]    gen_block,
  output logic [N*QUAN_SIZE-1:0]    dec_block,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [SNR_IDX_W-1:0]      dec_snr_idx,
  output logic [FRAME_CNT_W-1:0]    dec_frame_idx,
  output logic                      dec_last,
  output logic                      busy,
  output logic                      point_done,
  output logic                      done,
  output logic                      err_timeout,
  output logic [2:0]                dbg_state
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_REQUEST, S_HOLD, S_ADVANCE, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [15:0]              sigma_q, sigma_d, step_q, step_d;
  logic [SNR_IDX_W-1:0]     npts_q, npts_d, snr_q, snr_d;
  logic [FRAME_CNT_W-1:0]   fpp_q, fpp_d, frame_q, frame_d;
  logic [N*QUAN_SIZE-1:0]   blk_q, blk_d;
  logic                     last_frame, last_point;
`ifdef SCHED_TIMEOUT_EN
  logic                     err_q, err_d;
`endif

  assign last_frame = (frame_q == fpp_q - FRAME_CNT_W'(1));
  assign last_point = (snr_q == npts_q - SNR_IDX_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sigma_d = sigma_q;
    step_d  = step_q;
    npts_d  = npts_q;
    fpp_d   = fpp_q;
    snr_d   = snr_q;
    frame_d = frame_q;
    blk_d   = blk_q;
`ifdef SCHED_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SCHED_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (num_points == '0 || frames_per_point == '0) begin
            state_d = S_DONE;
          end else begin
            sigma_d = sigma_init;
            step_d  = sigma_step;
            npts_d  = num_points;
            fpp_d   = frames_per_point;
            snr_d   = '0;
            frame_d = '0;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_REQUEST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQUEST: begin
        if (gen_tvalid) begin
          blk_d   = gen_block;
          state_d = S_HOLD;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      // Decoder handshake: a block transfers in any cycle where dec_valid and
      // dec_ready are both high; dec_block and the indices hold until then.
      S_HOLD: begin
        if (dec_ready) begin
          if (!last_frame) begin
            frame_d = frame_q + FRAME_CNT_W'(1);
            cnt_d   = '0;
            state_d = S_REQUEST;
          end else if (!last_point) begin
            state_d = S_ADVANCE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADVANCE: begin
        sigma_d = (sigma_q < step_q) ? 16'd0 : sigma_q - step_q;
        snr_d   = snr_q + SNR_IDX_W'(1);
        frame_d = '0;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A start arriving with abort in IDLE is still honoured.
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sigma_q <= '0;
      step_q  <= '0;
      npts_q  <= '0;
      fpp_q   <= '0;
      snr_q   <= '0;
      frame_q <= '0;
      blk_q   <= '0;
`ifdef SCHED_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sigma_q <= sigma_d;
      step_q  <= step_d;
      npts_q  <= npts_d;
      fpp_q   <= fpp_d;
      snr_q   <= snr_d;
      frame_q <= frame_d;
      blk_q   <= blk_d;
`ifdef SCHED_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign gen_sigma     = sigma_q;
  assign gen_ready     = (state_q == S_REQUEST);
  assign dec_valid     = (state_q == S_HOLD);
  assign dec_block     = blk_q;
  assign dec_snr_idx   = snr_q;
  assign dec_frame_idx = frame_q;
  assign dec_last      = (state_q == S_HOLD) && last_frame && last_point;
  assign busy          = (state_q != S_IDLE);
  assign point_done    = (state_q == S_ADVANCE);
  assign done          = (state_q == S_DONE) && !abort;
  assign dbg_state     = state_q;
`ifdef SCHED_TIMEOUT_EN
  assign err_timeout   = err_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_snr_sweep_scheduler.sv
// Bench for snr_sweep_scheduler: random generator/decoder timing, reference sweep
// model feeding an expected queue, and a monitor that checks every decoder transfer.
module tb_snr_sweep_scheduler;
  localparam int N = 204, Q = 4, BW = N * Q, FW = 16, SW = 4;
  localparam int SETTLE = 4, TMO = 4096;
  localparam int EW = 1 + SW + FW + 16;

  logic           sys_clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0]    sigma_init = '0, sigma_step = '0;
  logic [SW-1:0]  num_points = '0;
  logic [FW-1:0]  frames_per_point = '0;
  logic [15:0]    gen_sigma;
  logic           gen_ready, gen_tvalid, dec_valid, dec_ready, dec_last;
  logic [BW-1:0]  gen_block, dec_block;
  logic [SW-1:0]  dec_snr_idx;
  logic [FW-1:0]  dec_frame_idx;
  logic           busy, point_done, done, err_timeout;
  logic [2:0]     dbg_state;

  logic [EW-1:0]  exp_q[$];
  logic [BW-1:0]  blk_q[$];
  logic [15:0]    sig_q[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int done_cnt = 0, pd_cnt = 0, xfer_cnt = 0, last_hs_cyc = -10, done_cyc = -10;
  bit sb_en = 1'b0, gen_en = 1'b0, rdy_rand = 1'b0;

  snr_sweep_scheduler dut (
    .sys_clk(sys_clk), .rstn(rstn), .start(start), .abort(abort),
    .sigma_init(sigma_init), .sigma_step(sigma_step), .num_points(num_points),
    .frames_per_point(frames_per_point), .gen_sigma(gen_sigma), .gen_ready(gen_ready),
    .gen_tvalid(gen_tvalid), .gen_block(gen_block), .dec_block(dec_block),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_snr_idx(dec_snr_idx),
    .dec_frame_idx(dec_frame_idx), .dec_last(dec_last), .busy(busy),
    .point_done(point_done), .done(done), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic sample();
    @(negedge sys_clk); #1;
  endtask

  task automatic flush();
    exp_q.delete(); blk_q.delete(); sig_q.delete();
  endtask

  // generator model plus decoder ready driver
  initial begin
    gen_tvalid = 1'b0; gen_block = '0; dec_ready = 1'b0;
    forever begin
      step();
      gen_tvalid = 1'b0;
      if (gen_en && rstn) begin
        if (gen_ready && $urandom_range(0, 2) == 0) begin
          for (int i = 0; i < BW / 8; i++) gen_block[i*8 +: 8] = 8'($urandom_range(0, 255));
          gen_tvalid = 1'b1;
          blk_q.push_back(gen_block);
          sig_q.push_back(gen_sigma);
        end else if (!gen_ready && $urandom_range(0, 4) == 0) begin
          for (int i = 0; i < BW / 8; i++) gen_block[i*8 +: 8] = 8'($urandom_range(0, 255));
          gen_tvalid = 1'b1;
        end
      end
      if (rdy_rand) dec_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor / scoreboard
  logic [BW-1:0]  p_blk;
  logic [SW+FW+1:0] p_ctl;
  bit             p_stall = 1'b0;
  always @(negedge sys_clk) begin
    logic [EW-1:0] e;
    logic [BW-1:0] b;
    logic [15:0]   s;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (point_done) pd_cnt++;
    if (sb_en && p_stall) begin
      chk("hold_block_stable", dec_block, p_blk);
      chk("hold_ctrl_stable", {dec_valid, gen_ready, dec_snr_idx, dec_frame_idx}, p_ctl);
    end
    p_stall = sb_en && dec_valid && !dec_ready;
    p_blk   = dec_block;
    p_ctl   = {1'b1, 1'b0, dec_snr_idx, dec_frame_idx};
    if (sb_en && dec_valid && dec_ready) begin
      xfer_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0 || blk_q.size() == 0 || sig_q.size() == 0) begin
        chk("unexpected_transfer", 1, 0);
      end else begin
        e = exp_q.pop_front(); b = blk_q.pop_front(); s = sig_q.pop_front();
        chk("xfer_ctrl", {gen_ready, dec_last, dec_snr_idx, dec_frame_idx, s}, {1'b0, e});
        chk("xfer_block", dec_block, b);
      end
    end
  end

  task automatic run_sweep(input logic [15:0] si, input logic [15:0] st,
                           input logic [SW-1:0] np, input logic [FW-1:0] fpp);
    int v;
    bit gr_early;
    for (int p = 0; p < int'(np); p++) begin
      v = int'(si) - p * int'(st);
      if (v < 0) v = 0;
      for (int f = 0; f < int'(fpp); f++)
        exp_q.push_back({(p == int'(np) - 1) && (f == int'(fpp) - 1), SW'(p), FW'(f), 16'(v)});
    end
    step();
    done_cnt = 0; pd_cnt = 0;
    sigma_init = si; sigma_step = st; num_points = np; frames_per_point = fpp; start = 1'b1;
    step();
    start = 1'b0;
    sigma_init = 16'($urandom); sigma_step = 16'($urandom);
    num_points = SW'($urandom); frames_per_point = FW'($urandom);
    sample();
    chk("busy_rise", busy, 1'b1);
    chk("err_clear_on_start", err_timeout, 1'b0);
    gr_early = 1'b0;
    for (int j = 0; j < SETTLE; j++) begin
      gr_early |= gen_ready;
      if (j < SETTLE - 1) sample();
    end
    chk("settle_ready_low", gr_early, 1'b0);
    sample();
    chk("ready_after_settle", gen_ready, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      if (done_cnt > 0) break;
      sample();
    end
    chk("sweep_done_seen", done_cnt > 0, 1'b1);
    chk("done_after_last_hs", done_cyc, last_hs_cyc + 1);
    sample();
    chk("busy_fall", busy, 1'b0);
    chk("done_once", done_cnt, 1);
    chk("point_done_count", pd_cnt, int'(np) - 1);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("blk_q_drained", blk_q.size(), 0);
    chk("err_idle", err_timeout, 1'b0);
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sample();
      if (dec_valid) begin ok = 1'b1; break; end
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic zero_cfg(input logic [SW-1:0] np, input logic [FW-1:0] fpp);
    bit gr;
    step();
    done_cnt = 0; gr = 1'b0;
    num_points = np; frames_per_point = fpp; sigma_init = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin sample(); gr |= gen_ready; end
    chk("zero_cfg_done", done_cnt, 1);
    chk("zero_cfg_no_ready", gr, 1'b0);
    chk("zero_cfg_idle", busy, 1'b0);
  endtask

  initial begin
    repeat (3) sample();
    chk("rst_outputs", {busy, gen_ready, dec_valid, dec_last, point_done, done, err_timeout}, '0);
    chk("rst_sigma_idx", {gen_sigma, dec_snr_idx, dec_frame_idx}, '0);
    chk("rst_block", dec_block, '0);
    step(); rstn = 1'b1;
    sb_en = 1'b1; gen_en = 1'b1;

    // basic sweep with decoder always ready
    dec_ready = 1'b1;
    run_sweep(16'h4000, 16'h0800, 4'd2, 16'd3);

    // backpressure: 20 stalled cycles then a single release
    dec_ready = 1'b0;
    xfer_cnt = 0;
    fork
      run_sweep(16'h2222, 16'h0100, 4'd1, 16'd1);
      begin
        wait_valid("bp_valid");
        repeat (20) step();
        chk("bp_no_xfer_while_stalled", xfer_cnt, 0);
        dec_ready = 1'b1;
      end
    join
    chk("bp_one_xfer", xfer_cnt, 1);

    // saturation and random sweeps under random backpressure
    rdy_rand = 1'b1;
    run_sweep(16'h0100, 16'h0800, 4'd3, 16'd1);
    for (int r = 0; r < 4; r++)
      run_sweep(16'($urandom), 16'($urandom_range(0, 16'h3000)),
                SW'($urandom_range(1, 4)), FW'($urandom_range(1, 3)));

    zero_cfg(4'd0, 16'd5);
    zero_cfg(4'd3, 16'd0);

    // abort during HOLD coincident with dec_ready
    sb_en = 1'b0; rdy_rand = 1'b0; dec_ready = 1'b0;
    step();
    sigma_init = 16'h3000; sigma_step = 16'h0400; num_points = 4'd2; frames_per_point = 16'd2;
    start = 1'b1;
    step(); start = 1'b0;
    wait_valid("abort_valid");
    step();
    done_cnt = 0; dec_ready = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0; dec_ready = 1'b0;
    sample();
    chk("abort_idle", {busy, dec_valid, gen_ready}, 3'b000);
    repeat (4) sample();
    chk("abort_no_done", done_cnt, 0);
    flush();
    sb_en = 1'b1; rdy_rand = 1'b1;
    run_sweep(16'h5000, 16'h1000, 4'd2, 16'd2);

    // asynchronous reset mid-sweep
    sb_en = 1'b0; rdy_rand = 1'b0; dec_ready = 1'b0;
    step();
    sigma_init = 16'h7777; num_points = 4'd2; frames_per_point = 16'd2; start = 1'b1;
    step(); start = 1'b0;
    wait_valid("arst_valid");
    #2 rstn = 1'b0;
    #1;
    chk("arst_ctrl", {busy, dec_valid, gen_ready, dec_snr_idx, dec_frame_idx, gen_sigma}, '0);
    chk("arst_block", dec_block, '0);
    step(); rstn = 1'b1;
    flush();
    sb_en = 1'b1; rdy_rand = 1'b1;

`ifdef SCHED_TIMEOUT_EN
    // watchdog: generator silent
    gen_en = 1'b0; done_cnt = 0;
    step();
    num_points = 4'd1; frames_per_point = 16'd1; start = 1'b1;
    step(); start = 1'b0;
    sample();
    repeat (SETTLE + TMO - 1) sample();
    chk("wd_not_yet", {err_timeout, busy}, 2'b01);
    sample();
    chk("wd_fired", {err_timeout, busy}, 2'b10);
    chk("wd_no_done", done_cnt, 0);
    gen_en = 1'b1;
    run_sweep(16'h0900, 16'h0100, 4'd1, 16'd2);
`else
    // without the watchdog REQUEST waits indefinitely
    gen_en = 1'b0;
    step();
    num_points = 4'd1; frames_per_point = 16'd1; start = 1'b1;
    step(); start = 1'b0;
    repeat (SETTLE + 200) sample();
    chk("no_wd_waiting", {err_timeout, busy, gen_ready}, 3'b011);
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    gen_en = 1'b1;
    run_sweep(16'h0900, 16'h0100, 4'd1, 16'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
